// File: rtl/chess_move_controller.sv
// Chess game sequencer: cursor, selection, move commit and turn tracking.
// Define PAWN_PROMOTE_EN to promote pawns reaching the last rank to queens.
module chess_move_controller #(
    parameter bit         CURSOR_WRAP = 1'b1,
    parameter logic [5:0] INIT_CURSOR = 6'd52,
    parameter logic       START_TURN  = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    output logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         TURN,
    output logic         MOVE_DONE,
    output logic [3:0]   LAST_CAPTURE
);

    // Square s occupies bits [4s+3:4s]; row 0 (black back rank) is the low word.
    localparam logic [255:0] INIT_BOARD =
        256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

    typedef enum logic [1:0] {
        PICK   = 2'd0,
        DEST   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [255:0]   board_n;
    logic [5:0]     cursor_n, sel_n, dest, dest_n, stepped;
    logic           sel_en_n, turn_n, done_n;
    logic [3:0]     capture_n;
    logic [3:0]     cur_piece, src_piece, dst_piece, moved;
    logic [2:0]     row_n, col_n;
    logic           own;

    assign cur_piece = BOARD[{CURSOR_ADDR, 2'b00} +: 4];
    assign src_piece = BOARD[{SELECT_ADDR, 2'b00} +: 4];
    assign dst_piece = BOARD[{dest, 2'b00} +: 4];
    assign own       = (cur_piece[2:0] != 3'd0) && (cur_piece[3] == TURN);

    // Directional step with UP > DOWN > LEFT > RIGHT priority.
    always_comb begin
        row_n = CURSOR_ADDR[5:3];
        col_n = CURSOR_ADDR[2:0];
        if (BTN_UP) begin
            if (CURSOR_WRAP || row_n != 3'd0) row_n = row_n - 3'd1;
        end else if (BTN_DOWN) begin
            if (CURSOR_WRAP || row_n != 3'd7) row_n = row_n + 3'd1;
        end else if (BTN_LEFT) begin
            if (CURSOR_WRAP || col_n != 3'd0) col_n = col_n - 3'd1;
        end else if (BTN_RIGHT) begin
            if (CURSOR_WRAP || col_n != 3'd7) col_n = col_n + 3'd1;
        end
        stepped = {row_n, col_n};
    end

    always_comb begin
        moved = src_piece;
`ifdef PAWN_PROMOTE_EN
        if (src_piece == 4'h1 && dest[5:3] == 3'd0) begin
            moved = 4'h5;
        end else if (src_piece == 4'h9 && dest[5:3] == 3'd7) begin
            moved = 4'hD;
        end
`else
        moved = src_piece;
`endif
    end

    always_comb begin
        state_n   = state;
        board_n   = BOARD;
        cursor_n  = CURSOR_ADDR;
        sel_n     = SELECT_ADDR;
        sel_en_n  = SELECT_EN;
        turn_n    = TURN;
        dest_n    = dest;
        done_n    = 1'b0;
        capture_n = LAST_CAPTURE;
        unique case (state)
            PICK: begin
                if (BTN_CENTER) begin
                    if (own) begin
                        sel_n    = CURSOR_ADDR;
                        sel_en_n = 1'b1;
                        state_n  = DEST;
                    end
                end else begin
                    cursor_n = stepped;
                end
            end
            DEST: begin
                if (BTN_CENTER) begin
                    if (CURSOR_ADDR == SELECT_ADDR) begin
                        sel_en_n = 1'b0;
                        state_n  = PICK;
                    end else if (own) begin
                        sel_n = CURSOR_ADDR;
                    end else begin
                        dest_n  = CURSOR_ADDR;
                        state_n = COMMIT;
                    end
                end else begin
                    cursor_n = stepped;
                end
            end
            COMMIT: begin
                board_n[{SELECT_ADDR, 2'b00} +: 4] = 4'h0;
                board_n[{dest, 2'b00} +: 4]        = moved;
                capture_n = dst_piece;
                turn_n    = ~TURN;
                sel_en_n  = 1'b0;
                done_n    = 1'b1;
                state_n   = PICK;
            end
            default: state_n = PICK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= PICK;
            BOARD        <= INIT_BOARD;
            CURSOR_ADDR  <= INIT_CURSOR;
            SELECT_ADDR  <= 6'd0;
            SELECT_EN    <= 1'b0;
            TURN         <= START_TURN;
            MOVE_DONE    <= 1'b0;
            LAST_CAPTURE <= 4'h0;
            dest         <= 6'd0;
        end else begin
            state        <= state_n;
            BOARD        <= board_n;
            CURSOR_ADDR  <= cursor_n;
            SELECT_ADDR  <= sel_n;
            SELECT_EN    <= sel_en_n;
            TURN         <= turn_n;
            MOVE_DONE    <= done_n;
            LAST_CAPTURE <= capture_n;
            dest         <= dest_n;
        end
    end

endmodule

// File: tb/tb_chess_move_controller.sv
// Scoreboard bench for chess_move_controller: directed cursor, selection and move vectors.
// Expected commits are queued at stimulus time and checked when MOVE_DONE fires.
module tb_chess_move_controller;

    localparam logic [255:0] INIT_BOARD =
        256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;
`ifdef PAWN_PROMOTE_EN
    localparam logic [3:0] PROMO_W = 4'h5;
    localparam logic [3:0] PROMO_B = 4'hD;
`else
    localparam logic [3:0] PROMO_W = 4'h1;
    localparam logic [3:0] PROMO_B = 4'h9;
`endif

    typedef struct {
        int         src;
        int         dst;
        logic [3:0] code;
        logic [3:0] cap;
        logic       turn;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   btns = 5'd0;
    logic [255:0] board;
    logic [5:0]   cursor, sel;
    logic         sel_en, turn, done;
    logic [3:0]   cap;
    logic [255:0] sat_board;
    logic [5:0]   sat_cursor, sat_sel;
    logic         sat_sel_en, sat_turn, sat_done;
    logic [3:0]   sat_cap;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   cur = 52;
    logic prev_done = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chess_move_controller dut (
        .CLK(clk), .RESET(rst),
        .BTN_UP(btns[3]), .BTN_DOWN(btns[2]),
        .BTN_LEFT(btns[1]), .BTN_RIGHT(btns[0]),
        .BTN_CENTER(btns[4]),
        .BOARD(board), .CURSOR_ADDR(cursor),
        .SELECT_ADDR(sel), .SELECT_EN(sel_en),
        .TURN(turn), .MOVE_DONE(done),
        .LAST_CAPTURE(cap)
    );

    chess_move_controller #(.CURSOR_WRAP(1'b0)) dut_sat (
        .CLK(clk), .RESET(rst),
        .BTN_UP(1'b0), .BTN_DOWN(1'b0),
        .BTN_LEFT(1'b0), .BTN_RIGHT(btns[0]),
        .BTN_CENTER(1'b0),
        .BOARD(sat_board), .CURSOR_ADDR(sat_cursor),
        .SELECT_ADDR(sat_sel), .SELECT_EN(sat_sel_en),
        .TURN(sat_turn), .MOVE_DONE(sat_done),
        .LAST_CAPTURE(sat_cap)
    );

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sq(input int s);
        return board[s*4 +: 4];
    endfunction

    // Monitor: pops one expected commit per MOVE_DONE pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                check("done_single_pulse", prev_done, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_move", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("move_latency", cyc, e.cyc);
                    check("move_dst", sq(e.dst), e.code);
                    check("move_src", sq(e.src), 4'h0);
                    check("move_capture", cap, e.cap);
                    check("move_turn", turn, e.turn);
                    check("move_sel_en", sel_en, 1'b0);
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        btns = m;
        @(negedge clk);
        btns = 5'd0;
    endtask

    task automatic move_to(input int t);
        int guard = 0;
        while (cur != t && guard < 32) begin
            if (cur / 8 > t / 8) begin
                press(5'b01000); cur -= 8;
            end else if (cur / 8 < t / 8) begin
                press(5'b00100); cur += 8;
            end else if (cur % 8 > t % 8) begin
                press(5'b00010); cur -= 1;
            end else begin
                press(5'b00001); cur += 1;
            end
            guard++;
        end
        check("cursor_move", cursor, t);
    endtask

    task automatic commit(input int s, input int d, input logic [3:0] code,
                          input logic [3:0] c, input logic t);
        exp_t e;
        @(negedge clk);
        e = '{src: s, dst: d, code: code, cap: c, turn: t, cyc: cyc + 2};
        sb.push_back(e);
        btns = 5'b10000;
        @(negedge clk);
        btns = 5'd0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_sq0", board[3:0], 4'hC);
        check("rst_sq4", board[19:16], 4'hE);
        check("rst_sq63", board[255:252], 4'h4);
        check("rst_sq52", sq(52), 4'h1);
        check("rst_board", board, INIT_BOARD);
        check("rst_cursor", cursor, 6'd52);
        check("rst_turn", turn, 1'b0);
        check("rst_sel_en", sel_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_capture", cap, 4'h0);

        // Wrap vs saturate at the right edge
        repeat (3) press(5'b00001);
        cur = 55;
        check("walk_right", cursor, 6'd55);
        check("sat_walk_right", sat_cursor, 6'd55);
        press(5'b00001);
        cur = 48;
        check("wrap_right", cursor, 6'd48);
        check("sat_right", sat_cursor, 6'd55);
        move_to(4);
        press(5'b01000);
        cur = 60;
        check("wrap_up", cursor, 6'd60);

        // Priority
        move_to(52);
        press(5'b01101);
        cur = 44;
        check("prio_up", cursor, 6'd44);
        press(5'b11000);
        check("prio_center_cursor", cursor, 6'd44);
        check("center_empty_sel", sel_en, 1'b0);

        // Opponent piece is not selectable
        move_to(12);
        press(5'b10000);
        check("opp_sel_en", sel_en, 1'b0);

        // Select then deselect
        move_to(52);
        press(5'b10000);
        check("sel_en", sel_en, 1'b1);
        check("sel_addr", sel, 6'd52);
        press(5'b10000);
        check("desel_en", sel_en, 1'b0);
        check("desel_board", board, INIT_BOARD);

        // Reselect an own piece
        press(5'b10000);
        press(5'b00001);
        cur = 53;
        press(5'b10000);
        check("resel_addr", sel, 6'd53);
        check("resel_en", sel_en, 1'b1);
        press(5'b10000);
        check("resel_desel", sel_en, 1'b0);

        // e2-e4 equivalent: 52 -> 36
        move_to(52);
        press(5'b10000);
        check("sel52", sel, 6'd52);
        move_to(36);
        commit(52, 36, 4'h1, 4'h0, 1'b1);
        check("turn_black", turn, 1'b1);
        check("done_low", done, 1'b0);

        move_to(12);
        press(5'b10000);
        move_to(20);
        commit(12, 20, 4'h9, 4'h0, 1'b0);

        move_to(48);
        press(5'b10000);
        move_to(8);
        commit(48, 8, 4'h1, 4'h9, 1'b1);

        move_to(13);
        press(5'b10000);
        move_to(21);
        commit(13, 21, 4'h9, 4'h0, 1'b0);

        move_to(8);
        press(5'b10000);
        move_to(0);
        commit(8, 0, PROMO_W, 4'hC, 1'b1);
        check("cap_rook", cap, 4'hC);
        check("sq0_code", sq(0), PROMO_W);

        move_to(20);
        press(5'b10000);
        move_to(60);
        commit(20, 60, PROMO_B, 4'h6, 1'b0);

        // Reset while in COMMIT aborts the move
        move_to(36);
        press(5'b10000);
        move_to(28);
        press(5'b10000);
        rst = 1'b1;
        @(negedge clk);
        check("abort_done", done, 1'b0);
        check("abort_board", board, INIT_BOARD);
        check("abort_turn", turn, 1'b0);
        check("abort_sel_en", sel_en, 1'b0);
        check("abort_cursor", cursor, 6'd52);
        rst = 1'b0;
        cur = 52;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/chess_move_controller.md
Name: chess_move_controller

Overview:
- Game-level sequencer that owns the 256-bit board state and drives the board/cursor/selection inputs of the VGA display block.
- Turns debounced single-cycle button pulses into cursor motion, piece selection and move commits; alternates turns.
- Sits between the button debouncers and the display block in the top level; its registers are the single source of truth for board contents.

Parameters:
- CURSOR_WRAP, 1, 1 = cursor wraps within its row/column at edges; 0 = cursor saturates at edges.
- INIT_CURSOR, 6'd52, cursor square after reset.
- START_TURN, 1'b0, side to move after reset (0 = white, 1 = black).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BTN_UP  in  1  one-cycle pulse: cursor row-1
- BTN_DOWN  in  1  one-cycle pulse: cursor row+1
- BTN_LEFT  in  1  one-cycle pulse: cursor col-1
- BTN_RIGHT  in  1  one-cycle pulse: cursor col+1
- BTN_CENTER  in  1  one-cycle pulse: select / deselect / commit
- BOARD  out  256  square s in bits [4s+3:4s]; s = row*8+col, row 0 at top
- CURSOR_ADDR  out  6  current cursor square
- SELECT_ADDR  out  6  selected source square
- SELECT_EN  out  1  selection active
- TURN  out  1  side to move, 0 = white, 1 = black
- MOVE_DONE  out  1  one-cycle pulse on board update
- LAST_CAPTURE  out  4  piece code removed by the most recent move; 0 = none

Behaviour:
- Decided: one clock, CLK. RESET is synchronous and active-high; all outputs use registered assignment from CLK only.
- Piece code: bit3 = colour (1 = black); [2:0] = type: 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; 7 is illegal and never written.
- Reset values:
  - BOARD = standard setup. Row 0 = black R N B Q K B N R (cols 0..7). Row 1 = black pawns. Rows 2-5 empty. Row 6 = white pawns. Row 7 = white R N B Q K B N R.
  - CURSOR_ADDR = INIT_CURSOR; SELECT_ADDR = 0; SELECT_EN = 0; TURN = START_TURN; MOVE_DONE = 0; LAST_CAPTURE = 0; state = PICK.
  - RESET mid-move (any state) aborts the move; no partial board write.
- Button priority per cycle: CENTER > UP > DOWN > LEFT > RIGHT. Only the highest-priority asserted button acts; the others are dropped.
- Cursor:
  - Updates the cycle after the pulse.
  - Row/col arithmetic is 3-bit: CURSOR_WRAP = 1 wraps mod 8 (col 7 RIGHT -> col 0, same row); CURSOR_WRAP = 0 holds at 0/7.
  - Cursor moves are allowed in PICK and DEST; ignored in COMMIT.
- FSM:
  - PICK: CENTER on a square holding a piece whose colour == TURN -> SELECT_ADDR = cursor, SELECT_EN = 1, go to DEST. CENTER on an empty or opponent square is ignored.
  - DEST:
    - CENTER with cursor == SELECT_ADDR -> SELECT_EN = 0, go to PICK (deselect).
    - CENTER on a square holding an own-colour piece -> reselect: SELECT_ADDR = cursor, stay in DEST.
    - CENTER otherwise (empty or opponent square) -> latch dest = cursor, go to COMMIT.
  - COMMIT (exactly 1 cycle, all buttons ignored):
    - board[dest] = board[src]; board[src] = 0.
    - LAST_CAPTURE = old board[dest].
    - TURN toggles; SELECT_EN = 0; MOVE_DONE = 1 for this cycle only; go to PICK.
- Latency: CENTER at cycle n in DEST -> COMMIT state at n+1 -> BOARD, TURN and MOVE_DONE change at n+2.
- No chess move-legality checking beyond colour rules; capturing a king is permitted and just reported in LAST_CAPTURE.

Optional Feature:
- Macro PAWN_PROMOTE_EN.
- Defined: in COMMIT, a white pawn (code 1) landing on row 0 or a black pawn (code 9) landing on row 7 is written as a queen of the same colour (5 / 13).
- Undefined: the pawn code is copied unchanged. No other behaviour differs.

Test Plan:
- Reset -> BOARD[3:0] = 4'hC, BOARD[19:16] = 4'hE, BOARD[255:252] = 4'h4, square 52 = 4'h1; CURSOR_ADDR = 52; TURN = 0; SELECT_EN = 0.
- CURSOR_WRAP = 1: cursor 55, RIGHT -> 48; cursor 4, UP -> 60. CURSOR_WRAP = 0: cursor 55, RIGHT -> 55.
- Cursor 52, CENTER; UP ×2; CENTER -> SELECT_EN = 1 with SELECT_ADDR = 52. Two cycles after the second CENTER: square 36 = 1, square 52 = 0, TURN = 1, MOVE_DONE single pulse, LAST_CAPTURE = 0.
- TURN = 0, CENTER on square 12 (black pawn) -> no state change; SELECT_EN stays 0.
- Select 52, CENTER on 52 -> SELECT_EN = 0, BOARD unchanged. Select 52, CENTER on 53 -> SELECT_ADDR = 53, still in DEST.
- Place white pawn on 8, move to 0 (black rook) -> LAST_CAPTURE = 4'hC. Square 0 = 4'h5 with PAWN_PROMOTE_EN defined, 4'h1 without. RESET asserted during COMMIT -> board equals the reset layout.
